rs232_rx: RTL and testbench

- UART receiver for the link driven by rs232_tx: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line.
- Synchronises the asynchronous RX pin and samples each bit at mid-bit.
- Presents each received byte on DATA with a one-cycle DONE strobe for the downstream score-update logic.
- Flags bad stop bits and rejects start-bit glitches.

---
 rtl/rs232_rx.sv | 139 +++++++++++++
 tb/tb_rs232_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rs232_rx.sv
// UART receiver: 8N1, LSB first, idle-high line. Samples each bit at mid-bit,
// strobes DONE on a good frame, FERR on a low stop bit, and filters start glitches.
module rs232_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       DONE,
  output logic       FERR,
  output logic       BUSY
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic             rx_meta_q;
  logic             rx_s_q;
  logic [2:0]       state_q,   state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic [7:0]       data_q,    data_d;
  logic             done_q,    done_d;
  logic             ferr_q,    ferr_d;
  logic             busy_q,    busy_d;

  // State and output registers; synchroniser resets to the idle line level.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic; the bit counter restarts on every state or bit boundary.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (clk_cnt_q == HALF_END) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      // Hold off after a framing error until the line goes idle, so a break
      // is not decoded as a stream of zero frames.
      S_WAIT_IDLE: begin
        clk_cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign DATA = data_q;
  assign DONE = done_q;
  assign FERR = ferr_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_rs232_rx.sv
// Self-checking bench for rs232_rx: expected pulses are scheduled from the
// transmitted frames and the start-edge-to-DONE latency, then checked every cycle.
module tb_rs232_rx;

  localparam int unsigned C   = 16;
  localparam int unsigned H   = C / 2;
  localparam int unsigned LAT = 2 + H + 9 * C + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       done;
  logic       ferr;
  logic       busy;

  rs232_rx #(.CLKS_PER_BIT(C)) dut (
    .CLK  (clk),
    .RST  (rst_n),
    .RX   (rx),
    .DATA (data),
    .DONE (done),
    .FERR (ferr),
    .BUSY (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 1 = DONE expected, 2 = FERR expected
  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [7:0]  data;
  } ev_t;

  ev_t         evq[$];
  logic [7:0]  data_exp      = 8'h00;
  int          done_raw      = 0;
  int          ferr_raw      = 0;
  int unsigned last_done_cyc = 0;
  int          n_cmp         = 0;
  int          n_bad         = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one frame from a negedge; schedule the pulse it must produce.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int kind,
                            output int unsigned t);
    t = cyc;
    if (kind != 0) evq.push_back('{t + LAT, kind, d});
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (C) @(negedge clk);
    end
    rx = stop;
    repeat (C) @(negedge clk);
  endtask

  // Per-cycle comparison against the scheduled pulses and last good byte.
  initial begin
    ev_t ev;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ferr", 32'(ferr), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        data_exp = 8'h00;
      end else begin
        chk("done_ferr_excl", 32'(done & ferr), 32'h0);
        if (done) done_raw++;
        if (ferr) ferr_raw++;
        if (done || ferr) begin
          if (evq.size() == 0) begin
            chk("unexpected_pulse", 32'({done, ferr}), 32'h0);
          end else begin
            ev = evq.pop_front();
            chk("pulse_kind", done ? 32'd1 : 32'd2, 32'(ev.kind));
            chk("pulse_time_ok", 32'((cyc + 1 >= ev.cyc) && (cyc <= ev.cyc + 1)), 32'd1);
            if (done) begin
              data_exp      = ev.data;
              last_done_cyc = cyc;
            end
          end
        end
        if (evq.size() > 0 && cyc > evq[0].cyc + 1) begin
          chk("pulse_missing_due", cyc, evq[0].cyc);
          void'(evq.pop_front());
        end
        chk("data", 32'(data), 32'(data_exp));
      end
    end
  end

  initial begin
    int unsigned t;
    logic [7:0]  c3;

    // Reset held with a toggling line, then release on an idle line.
    repeat (20) @(negedge clk) rx = ~rx;
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * C) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_no_pulse", 32'(done_raw + ferr_raw), 32'h0);

    // Single frame D2 with latency check.
    send_frame(8'hD2, 1'b1, 1, t);
    repeat (4) @(negedge clk);
    chk("d2_data", 32'(data), 32'hD2);
    chk("d2_done_cnt", 32'(done_raw), 32'd1);
    chk("d2_ferr_cnt", 32'(ferr_raw), 32'd0);
    chk("d2_latency_ok", 32'((last_done_cyc - t >= 154) && (last_done_cyc - t <= 156)), 32'd1);
    chk("d2_busy_after", 32'(busy), 32'h0);

    // Back-to-back frames, no idle gap.
    send_frame(8'h55, 1'b1, 1, t);
    send_frame(8'h00, 1'b1, 1, t);
    send_frame(8'hFF, 1'b1, 1, t);
    repeat (2 * C) @(negedge clk);
    chk("b2b_data", 32'(data), 32'hFF);
    chk("b2b_done_cnt", 32'(done_raw), 32'd4);
    chk("b2b_ferr_cnt", 32'(ferr_raw), 32'd0);

    // Start glitch shorter than half a bit.
    rx = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_busy_hi", 32'(busy), 32'h1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_busy_lo", 32'(busy), 32'h0);
    chk("glitch_no_pulse", 32'(done_raw + ferr_raw), 32'd4);
    send_frame(8'hA5, 1'b1, 1, t);
    repeat (2 * C) @(negedge clk);
    chk("a5_data", 32'(data), 32'hA5);
    chk("a5_done_cnt", 32'(done_raw), 32'd5);

    // Framing error followed by a 40-bit break.
    send_frame(8'h3C, 1'b0, 2, t);
    repeat (40 * C) @(negedge clk);
    chk("brk_ferr_cnt", 32'(ferr_raw), 32'd1);
    chk("brk_done_cnt", 32'(done_raw), 32'd5);
    chk("brk_data_kept", 32'(data), 32'hA5);
    chk("brk_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    repeat (3 * C) @(negedge clk);
    chk("brk_busy_release", 32'(busy), 32'h0);
    send_frame(8'h81, 1'b1, 1, t);
    repeat (2 * C) @(negedge clk);
    chk("x81_data", 32'(data), 32'h81);
    chk("x81_done_cnt", 32'(done_raw), 32'd6);

    // Reset during data bit 4 of C3.
    c3 = 8'hC3;
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = c3[i];
      repeat (C) @(negedge clk);
    end
    rx = c3[4];
    repeat (8) @(negedge clk);
    chk("mid_busy_before_rst", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_data", 32'(data), 32'h0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * C) @(negedge clk);
    send_frame(8'h7E, 1'b1, 1, t);
    repeat (2 * C) @(negedge clk);
    chk("x7e_data", 32'(data), 32'h7E);
    chk("x7e_done_cnt", 32'(done_raw), 32'd7);
    chk("x7e_ferr_cnt", 32'(ferr_raw), 32'd1);
    chk("events_drained", 32'(evq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
